muldiv_controller: RTL and testbench
====================================

MULDIV_CONTROLLER -- requirements
Module: muldiv_controller

Interface
REQ-001 SHALL have the ports: clk, input, 1, sole clock, all state updates on the rising edge.
REQ-002 SHALL have the port: rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have the port: StartE, input, 1, E-stage request to start a mult/div operation.
REQ-004 SHALL have the port: OpE, input, 2, operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 SHALL have the ports: SrcAE and SrcBE, input, 32 each, operands A (multiplicand/dividend) and B (multiplier/divisor).
REQ-006 SHALL have the port: ReadHiLoD, input, 1, D-stage mfhi/mflo present.
REQ-007 SHALL have the ports: Hi and Lo, output, 32 each, architectural HI/LO registers.
REQ-008 SHALL have the port: Busy, output, 1, registered, high while an operation is iterating.
REQ-009 SHALL have the port: Done, output, 1, registered one-cycle pulse when HI/LO are updated.
REQ-010 SHALL have the port: StallMD, output, 1, combinational request to stall F/D and flush E: Busy && (StartE || ReadHiLoD).
REQ-011 SHALL have the port: DivZero, output, 1, present only when MULDIV_DIVZERO_EN is defined.

Function
REQ-012 SHALL implement the FSM states IDLE and BUSY; IDLE->BUSY on StartE in IDLE; BUSY->IDLE on the edge completing iteration 31.
REQ-013 SHALL capture on acceptance: op, operand magnitudes (two's-complement abs for signed ops), sign flags, and iteration counter=0.
REQ-014 SHALL ignore StartE while BUSY: no restart, no operand capture; StallMD holds the requester.
REQ-015 SHALL perform multiply as 32 iterations of shift-add, one bit per cycle, with a 64-bit product accumulator.
REQ-016 SHALL perform divide as 32 iterations of restoring division, one quotient bit per cycle, with a 33-bit partial remainder.
REQ-017 SHALL keep Busy high for exactly 32 cycles per operation, from the edge after acceptance.
REQ-018 SHALL, on the final edge, load Hi and Lo, drive Busy low, and drive Done high for one cycle.
REQ-019 SHALL update Hi/Lo only on completion; values are stable at all other times.
REQ-020 SHALL load MULT/MULTU results as Hi = product[63:32] and Lo = product[31:0]; MULT negates the 64-bit product when the operand signs differ.
REQ-021 SHALL load DIV/DIVU results as Lo = quotient and Hi = remainder; DIV negates the quotient when the signs differ and gives the remainder the sign of the dividend.
REQ-022 SHALL produce Lo=0x80000000 and Hi=0 for DIV 0x80000000 / 0xFFFFFFFF, without any fault.
REQ-023 SHALL allow a StartE in the same cycle as Done, accepting it (state is IDLE), so back-to-back operations have no gap beyond one cycle.
REQ-024 SHALL report ReadHiLoD with Busy low as no stall; Hi/Lo reflect the last completed operation.

Reset
REQ-025 SHALL force on rst, immediately and regardless of clk: state=IDLE, counter=0, Busy=0, Done=0, Hi=0, Lo=0, DivZero=0, with accumulators cleared.
REQ-026 SHALL abandon an in-flight operation on rst mid-operation without any Hi/Lo update; the first StartE after rst deasserts is accepted normally.

Configuration
REQ-027 SHALL, with MULDIV_DIVZERO_EN defined, complete DIV/DIVU with SrcBE=0 on the edge after acceptance (Busy high one cycle), leave Hi/Lo unchanged, and pulse DivZero together with Done.
REQ-028 SHALL, with MULDIV_DIVZERO_EN undefined, omit the DivZero port and run divide-by-zero the full 32 cycles, yielding DIVU Lo=0xFFFFFFFF and Hi=dividend.

Verification
REQ-029 SHALL cover: MULTU 0xFFFFFFFF x 0xFFFFFFFF -> after 32 Busy cycles, Hi=0xFFFFFFFE, Lo=0x00000001, and one Done pulse.
REQ-030 SHALL cover: MULT 0xFFFFFFFD (-3) x 7 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB.
REQ-031 SHALL cover: DIV -7 / 2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF; and DIVU 100 / 7 -> Lo=14, Hi=2.
REQ-032 SHALL cover: ReadHiLoD=1 at cycle 5 of Busy -> StallMD=1 until Busy falls, then 0; and StartE held during Busy does not restart.
REQ-033 SHALL cover: rst asserted at iteration 10 of DIVU 9/3 -> Busy=0, Hi=Lo=0 asynchronously, and no Done.
REQ-034 SHALL cover: DIVU 5/0 -> with MULDIV_DIVZERO_EN, Done and DivZero at 1 cycle with Hi/Lo unchanged; without it, Lo=0xFFFFFFFF and Hi=5 after 32 cycles.

Source files
------------

// File: rtl/muldiv_controller_if.sv
// Pipeline-side bundle for the iterative multiply/divide unit.
// Optional feature macro: MULDIV_DIVZERO_EN (adds DivZero and early divide-by-zero exit).
//
// Handshake: StartE is a request that is accepted on any rising edge where
// the unit is idle (Busy low). While Busy is high a request is not accepted
// and StallMD = Busy && (StartE || ReadHiLoD) holds the requester (and any
// mfhi/mflo reader) until Busy falls. Done pulses for one cycle on the edge
// that loads Hi/Lo. dbg_state mirrors the FSM (1 = BUSY).
interface muldiv_controller_if;
  logic        StartE;
  logic [1:0]  OpE;
  logic [31:0] SrcAE;
  logic [31:0] SrcBE;
  logic        ReadHiLoD;
  logic [31:0] Hi;
  logic [31:0] Lo;
  logic        Busy;
  logic        Done;
  logic        StallMD;
  logic        dbg_state;
`ifdef MULDIV_DIVZERO_EN
  logic        DivZero;
`endif

  modport master (
    output StartE, OpE, SrcAE, SrcBE, ReadHiLoD,
    input  Hi, Lo, Busy, Done, StallMD, dbg_state
`ifdef MULDIV_DIVZERO_EN
    , input DivZero
`endif
  );

  modport slave (
    input  StartE, OpE, SrcAE, SrcBE, ReadHiLoD,
    output Hi, Lo, Busy, Done, StallMD, dbg_state
`ifdef MULDIV_DIVZERO_EN
    , output DivZero
`endif
  );
endinterface

// File: rtl/muldiv_controller.sv
// Iterative MIPS-style HI/LO multiply/divide unit: 32-cycle shift-add
// multiply and 32-cycle restoring divide on operand magnitudes, with sign
// fix-up applied on the completing edge.
// Optional feature macro: MULDIV_DIVZERO_EN -- divide by zero finishes one
// cycle after acceptance, leaves Hi/Lo untouched and pulses DivZero.
module muldiv_controller (
  input  logic clk,
  input  logic rst,
  muldiv_controller_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [1:0]  op_q;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic        sign_a;
  logic        sign_b;
  logic [63:0] p;        // multiply: product accumulator; divide: [31:0] dividend/quotient
  logic [32:0] rem;      // divide partial remainder
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        busy_q;
  logic        done_q;
`ifdef MULDIV_DIVZERO_EN
  logic        dz_pend;
  logic        divzero_q;
`endif

  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [33:0] rem_wide;
  logic [33:0] div_diff;
  logic [32:0] rem_next;
  logic [31:0] quo_next;
  logic        signed_op;
  logic [63:0] prod_res;
  logic [31:0] quo_res;
  logic [31:0] rem_res;

  function automatic logic [31:0] mag32(input logic [31:0] x, input logic sgn);
    return (sgn && x[31]) ? (32'd0 - x) : x;
  endfunction

  // One iteration step for both datapaths plus the signed result fix-up.
  always_comb begin
    mul_sum   = {1'b0, p[63:32]} + (p[0] ? {1'b0, mag_a} : 33'd0);
    mul_next  = {mul_sum, p[31:1]};
    rem_wide  = {rem, p[31]};
    div_diff  = rem_wide - {2'b00, mag_b};
    if (div_diff[33]) begin
      rem_next = rem_wide[32:0];
      quo_next = {p[30:0], 1'b0};
    end else begin
      rem_next = div_diff[32:0];
      quo_next = {p[30:0], 1'b1};
    end
    signed_op = ~op_q[0];
    prod_res  = (signed_op && (sign_a ^ sign_b)) ? (64'd0 - mul_next) : mul_next;
    quo_res   = (signed_op && (sign_a ^ sign_b)) ? (32'd0 - quo_next) : quo_next;
    rem_res   = (signed_op && sign_a) ? (32'd0 - rem_next[31:0]) : rem_next[31:0];
  end

  // Control FSM, operand capture, iteration and HI/LO write-back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 5'd0;
      op_q   <= 2'd0;
      mag_a  <= 32'd0;
      mag_b  <= 32'd0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      p      <= 64'd0;
      rem    <= 33'd0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifdef MULDIV_DIVZERO_EN
      dz_pend   <= 1'b0;
      divzero_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef MULDIV_DIVZERO_EN
      divzero_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (bus.StartE) begin
            state  <= BUSY;
            busy_q <= 1'b1;
            cnt    <= 5'd0;
            op_q   <= bus.OpE;
            mag_a  <= mag32(bus.SrcAE, ~bus.OpE[0]);
            mag_b  <= mag32(bus.SrcBE, ~bus.OpE[0]);
            sign_a <= ~bus.OpE[0] & bus.SrcAE[31];
            sign_b <= ~bus.OpE[0] & bus.SrcBE[31];
            // Multiply seeds the multiplier in the low half; divide seeds the dividend.
            p      <= {32'd0, bus.OpE[1] ? mag32(bus.SrcAE, ~bus.OpE[0])
                                         : mag32(bus.SrcBE, ~bus.OpE[0])};
            rem    <= 33'd0;
`ifdef MULDIV_DIVZERO_EN
            dz_pend <= bus.OpE[1] && (bus.SrcBE == 32'd0);
`endif
          end
        end
        BUSY: begin
`ifdef MULDIV_DIVZERO_EN
          if (dz_pend) begin
            state     <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            divzero_q <= 1'b1;
            dz_pend   <= 1'b0;
          end else begin
`else
          begin
`endif
            p   <= op_q[1] ? {p[63:32], quo_next} : mul_next;
            rem <= rem_next;
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) begin
              state  <= IDLE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
              if (op_q[1]) begin
                hi_q <= rem_res;
                lo_q <= quo_res;
              end else begin
                hi_q <= prod_res[63:32];
                lo_q <= prod_res[31:0];
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Hi        = hi_q;
  assign bus.Lo        = lo_q;
  assign bus.Busy      = busy_q;
  assign bus.Done      = done_q;
  assign bus.StallMD   = busy_q && (bus.StartE || bus.ReadHiLoD);
  assign bus.dbg_state = (state == BUSY);
`ifdef MULDIV_DIVZERO_EN
  assign bus.DivZero   = divzero_q;
`endif

endmodule

// File: tb/tb_muldiv_controller.sv
// Directed bench for muldiv_controller: hand-computed HI/LO results, Busy
// length, Done pulse, stall behaviour, async reset and divide by zero.
module tb_muldiv_controller;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  muldiv_controller_if bus ();

  muldiv_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver: present a request for one edge, return at the first Busy cycle.
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.StartE = 1'b1;
    bus.OpE    = op;
    bus.SrcAE  = a;
    bus.SrcBE  = b;
    @(negedge clk);
    bus.StartE = 1'b0;
  endtask

  // Count Busy cycles (bounded) and return at the sample where Busy dropped.
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (bus.Busy === 1'b1 && cycles < 40) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic finish_op(input string tag, input int exp_cyc,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cyc;
    wait_done(cyc);
    check({tag, "_cycles"}, 64'(cyc), 64'(exp_cyc));
    check({tag, "_done"}, 64'(bus.Done), 64'd1);
    check({tag, "_hi"}, 64'(bus.Hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(bus.Lo), 64'(exp_lo));
`ifdef MULDIV_DIVZERO_EN
    check({tag, "_divzero"}, 64'(bus.DivZero), 64'd0);
`endif
  endtask

  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int exp_cyc,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    start_op(op, a, b);
    finish_op(tag, exp_cyc, exp_hi, exp_lo);
    @(negedge clk);
    check({tag, "_done_clr"}, 64'(bus.Done), 64'd0);
  endtask

  initial begin
    int cyc;
    int stall_bad;
    vectors     = 0;
    miscompares = 0;
    rst           = 1'b1;
    bus.StartE    = 1'b0;
    bus.OpE       = 2'b00;
    bus.SrcAE     = 32'd0;
    bus.SrcBE     = 32'd0;
    bus.ReadHiLoD = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_hi", 64'(bus.Hi), 64'd0);
    check("rst_lo", 64'(bus.Lo), 64'd0);
    check("rst_busy", 64'(bus.Busy), 64'd0);
    check("rst_done", 64'(bus.Done), 64'd0);
    check("rst_stall", 64'(bus.StallMD), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Arithmetic vectors
    do_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32, 32'hFFFFFFFE, 32'h00000001);
    do_op("mult_neg",  OP_MULT,  32'hFFFFFFFD, 32'd7,        32, 32'hFFFFFFFF, 32'hFFFFFFEB);
    do_op("div_neg",   OP_DIV,   32'hFFFFFFF9, 32'd2,        32, 32'hFFFFFFFF, 32'hFFFFFFFD);
    do_op("divu_100",  OP_DIVU,  32'd100,      32'd7,        32, 32'd2,        32'd14);
    do_op("div_ovf",   OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32, 32'd0,        32'h80000000);
    do_op("div_negb",  OP_DIV,   32'd7,        32'hFFFFFFFE, 32, 32'd1,        32'hFFFFFFFD);
    do_op("mult_pp",   OP_MULT,  32'hFFFFFFFE, 32'hFFFFFFFD, 32, 32'd0,        32'd6);

    // Back-to-back: next request presented in the Done cycle
    start_op(OP_MULTU, 32'd6, 32'd7);
    finish_op("b2b_first", 32, 32'd0, 32'd42);
    start_op(OP_DIVU, 32'd100, 32'd7);
    check("b2b_accept", 64'(bus.Busy), 64'd1);
    finish_op("b2b_second", 32, 32'd2, 32'd14);
    @(negedge clk);

    // Stall: StartE held for two Busy cycles (different operands), mfhi from cycle 5
    start_op(OP_MULTU, 32'd3, 32'd4);
    cyc = 0;
    stall_bad = 0;
    while (bus.Busy === 1'b1 && cyc < 40) begin
      cyc++;
      bus.StartE    = (cyc <= 2);
      bus.OpE       = OP_DIVU;
      bus.SrcAE     = 32'd100;
      bus.SrcBE     = 32'd7;
      bus.ReadHiLoD = (cyc >= 5);
      #1;
      if (bus.StallMD !== (bus.StartE || bus.ReadHiLoD)) stall_bad++;
      if (cyc == 5) check("stall_c5", 64'(bus.StallMD), 64'd1);
      @(negedge clk);
    end
    check("stall_cycles", 64'(cyc), 64'd32);
    check("stall_track", 64'(stall_bad), 64'd0);
    check("stall_idle_read", 64'(bus.StallMD), 64'd0);
    check("stall_done", 64'(bus.Done), 64'd1);
    check("stall_hi", 64'(bus.Hi), 64'd0);
    check("stall_lo", 64'(bus.Lo), 64'd12);
    bus.ReadHiLoD = 1'b0;
    @(negedge clk);

    // Async reset at iteration 10 of DIVU 9/3
    start_op(OP_DIVU, 32'd9, 32'd3);
    repeat (10) @(negedge clk);
    check("mid_busy", 64'(bus.Busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 64'(bus.Busy), 64'd0);
    check("arst_hi", 64'(bus.Hi), 64'd0);
    check("arst_lo", 64'(bus.Lo), 64'd0);
    check("arst_done", 64'(bus.Done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("arst_no_resume", 64'(bus.Busy), 64'd0);
    check("arst_no_done", 64'(bus.Done), 64'd0);
    check("arst_lo_held", 64'(bus.Lo), 64'd0);
    do_op("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32, 32'd0, 32'd3);

    // Divide by zero
`ifdef MULDIV_DIVZERO_EN
    start_op(OP_DIVU, 32'd5, 32'd0);
    wait_done(cyc);
    check("dz_cycles", 64'(cyc), 64'd1);
    check("dz_done", 64'(bus.Done), 64'd1);
    check("dz_flag", 64'(bus.DivZero), 64'd1);
    check("dz_hi", 64'(bus.Hi), 64'd0);
    check("dz_lo", 64'(bus.Lo), 64'd3);
    @(negedge clk);
    check("dz_done_clr", 64'(bus.Done), 64'd0);
    check("dz_flag_clr", 64'(bus.DivZero), 64'd0);
`else
    do_op("divu_zero", OP_DIVU, 32'd5, 32'd0, 32, 32'd5, 32'hFFFFFFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
